sdram_port_arbiter: RTL

- Shares the single SDRAM word read/write controller between three client ports: acquisition writer, TFT display reader, host/debug.
- Accepts per-client requests and picks one per transaction by round-robin.
- Drives the controller's level request / one-cycle done handshake, muxes address and write data, and returns read data and an ack to the granted client.
- Adds a watchdog that aborts a transaction the controller never completes.

---
 rtl/sdram_port_arbiter_if.sv | 34 +++
 rtl/sdram_port_arbiter.sv | 139 +++++++++++++
 2 files changed

// File: rtl/sdram_port_arbiter_if.sv
// Client and controller side signals of the SDRAM port arbiter.
// slave: the arbiter itself; master: clients plus controller.
interface sdram_port_arbiter_if #(
  parameter int AW = 22,
  parameter int DW = 16
);
  logic [2:0]      c_req;
  logic [2:0]      c_rw;
  logic [3*AW-1:0] c_addr;
  logic [3*DW-1:0] c_wdata;
  logic [2:0]      c_ack;
  logic            c_err;
  logic [DW-1:0]   c_rdata;
  logic [1:0]      m_req;
  logic [1:0]      m_done;
  logic [AW-1:0]   m_addr;
  logic [DW-1:0]   m_wdata;
  logic [DW-1:0]   m_rdata;
  logic            busy;

  modport slave (
    input  c_req, c_rw, c_addr, c_wdata,
    input  m_done, m_rdata,
    output c_ack, c_err, c_rdata,
    output m_req, m_addr, m_wdata, busy
  );

  modport master (
    output c_req, c_rw, c_addr, c_wdata,
    output m_done, m_rdata,
    input  c_ack, c_err, c_rdata,
    input  m_req, m_addr, m_wdata, busy
  );
endinterface

// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter sharing one SDRAM word controller
// between three clients, with a WAIT watchdog.
module sdram_port_arbiter #(
  parameter int          AW  = 22,
  parameter int          DW  = 16,
  parameter logic [11:0] TMO = 12'd2047
) (
  input logic clk,
  input logic rst_n,
  sdram_port_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT, ABORT, RESP
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    last_q, last_d;
  logic [1:0]    win_q, win_d;
  logic          rw_q, rw_d;
  logic          err_q, err_d;
  logic [11:0]   cnt_q, cnt_d;
  logic [1:0]    m_req_q, m_req_d;
  logic [AW-1:0] m_addr_q, m_addr_d;
  logic [DW-1:0] m_wdata_q, m_wdata_d;
  logic [DW-1:0] c_rdata_q, c_rdata_d;
  logic [2:0]    c_ack_q, c_ack_d;

  logic [1:0] p1, p2, pick;
  logic       done_hit;

  function automatic logic [1:0] nxt(input logic [1:0] a);
    return (a == 2'd2) ? 2'd0 : a + 2'd1;
  endfunction

  // Round-robin pick: first requester after the last grant.
  always_comb begin
    p1   = nxt(last_q);
    p2   = nxt(p1);
    pick = last_q;
    if (bus.c_req[p1])      pick = p1;
    else if (bus.c_req[p2]) pick = p2;
  end

  assign done_hit = rw_q ? bus.m_done[1] : bus.m_done[0];

  // Transaction sequencing, latching and watchdog.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    win_d     = win_q;
    rw_d      = rw_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    m_req_d   = m_req_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    c_rdata_d = c_rdata_q;
    c_ack_d   = 3'b000;
    unique case (state_q)
      IDLE: begin
        if (|bus.c_req) begin
          win_d     = pick;
          last_d    = pick;
          rw_d      = bus.c_rw[pick];
          m_addr_d  = bus.c_addr[int'(pick)*AW +: AW];
          m_wdata_d = bus.c_wdata[int'(pick)*DW +: DW];
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        m_req_d = rw_q ? 2'b10 : 2'b01;
        cnt_d   = 12'd0;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q + 12'd1;
        if (done_hit) begin
          m_req_d = 2'b00;
          if (!rw_q) c_rdata_d = bus.m_rdata;
          c_ack_d = 3'b001 << win_q;
          state_d = RESP;
        end else if (cnt_d == TMO) begin
          m_req_d = 2'b00;
          state_d = ABORT;
        end
      end
      ABORT: begin
        m_req_d = 2'b00;
        err_d   = 1'b1;
        c_ack_d = 3'b001 << win_q;
        state_d = RESP;
      end
      RESP: begin
        err_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      last_q    <= 2'd2;
      win_q     <= 2'd0;
      rw_q      <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= 12'd0;
      m_req_q   <= 2'b00;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      c_rdata_q <= '0;
      c_ack_q   <= 3'b000;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      win_q     <= win_d;
      rw_q      <= rw_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
      m_req_q   <= m_req_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      c_rdata_q <= c_rdata_d;
      c_ack_q   <= c_ack_d;
    end
  end

  assign bus.m_req   = m_req_q;
  assign bus.m_addr  = m_addr_q;
  assign bus.m_wdata = m_wdata_q;
  assign bus.c_rdata = c_rdata_q;
  assign bus.c_ack   = c_ack_q;
  assign bus.c_err   = err_q;
  assign bus.busy    = (state_q != IDLE);

endmodule
